elevator_car_ctrl: RTL and testbench
====================================

Name: elevator_car_ctrl

Overview:
Parametrised single-car elevator controller, successor to the fixed 4-floor, fixed-sweep controller. It serves floor requests latched from a call bitmask using a SCAN (sweep) policy over NUM_FLOORS floors, with programmable travel and door-dwell times. It reports floor, direction, door and arrival status. Multi-car designs instantiate one per car next to a dispatcher.

Parameters:
NUM_FLOORS, 4, number of floors served (2..16); floor index 0 = lowest.
TRAVEL_TICKS, 50000000, clk cycles to move one floor (>=1).
DOOR_TICKS, 100000000, clk cycles the door stays open per stop (>=1).
FLOOR_W, $clog2(NUM_FLOORS), floor index width (derived, not overridden).

Ports:
clk  in  1  system clock, all logic on posedge.
rst_n  in  1  reset, asynchronous, active-low.
call_req  in  NUM_FLOORS  one bit per floor; a 1 on any cycle registers a request for that floor.
door_hold  in  1  while 1 during DOOR_OPEN, the dwell counter is held at 0.
floor_o  out  FLOOR_W  current (last reached) floor.
dir_o  out  2  00 none, 01 up, 10 down; non-zero only in MOVING.
door_open_o  out  1  1 exactly while in DOOR_OPEN.
arrive_o  out  1  one-cycle pulse on the cycle floor_o updates.
pending_o  out  NUM_FLOORS  latched, not-yet-served requests.
busy_o  out  1  1 when state != IDLE or pending_o != 0.

Behaviour:
- Reset (async assert, sync release): state IDLE, floor_o=0, dir_o=00, door_open_o=0, arrive_o=0, pending=0, sweep=up, counters=0.
- Request latch: each cycle, pending_next = (pending | call_req) & ~serve_mask. serve_mask = the current-floor bit on the cycle the FSM enters DOOR_OPEN, or on any DOOR_OPEN cycle where call_req hits the current floor. A call for the current floor during DOOR_OPEN is absorbed and restarts dwell (counter to 0).
- "ahead(d)" = any bit of (pending|call_req) strictly above floor_o for d=up, strictly below for d=down.
- IDLE:
  - If (pending|call_req)[floor_o] is set, go to DOOR_OPEN next cycle.
  - Else if ahead(sweep), go to MOVING in sweep.
  - Else if ahead(~sweep), flip sweep and go to MOVING.
  - Else stay.
  - Latency: request to DOOR_OPEN or MOVING is 1 cycle.
- MOVING:
  - dir_o = sweep; travel counter counts 0..TRAVEL_TICKS-1.
  - On the terminal count: floor_o += 1 (up) or -= 1 (down), arrive_o=1, counter cleared.
  - If (pending|call_req)[new floor] is set, go to DOOR_OPEN.
  - Else if ahead(sweep) from the new floor, stay MOVING.
  - Else go to IDLE.
  - Each floor step takes exactly TRAVEL_TICKS cycles.
- DOOR_OPEN:
  - dir_o=00, door_open_o=1.
  - Dwell counter counts 0..DOOR_TICKS-1, and is held at 0 while door_hold=1.
  - On the terminal count, go to IDLE (re-evaluation happens the next cycle).
  - Minimum stay is DOOR_TICKS cycles.
- Boundaries:
  - floor_o never leaves 0..NUM_FLOORS-1, because ahead() is false past the ends.
  - sweep is never flipped while MOVING.
  - Requests arriving mid-travel for floors behind the car wait for the reverse sweep.
  - A request for the arrival floor on the arrival cycle is served at that stop.
  - Reset mid-MOVING or mid-DOOR_OPEN returns to floor 0, IDLE, with pending cleared.
- Arithmetic: counters are $clog2(max(TRAVEL_TICKS,DOOR_TICKS)+1) bits, unsigned; floor inc/dec is FLOOR_W-bit and cannot wrap, by construction.

Decomposition:
- Shared package elev_pkg:
  - Direction constants DIR_NONE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10, shared with the existing controller's encoding.
  - FSM state enum {IDLE, MOVING, DOOR_OPEN}.
- One sub-module, elev_tick_counter:
  - Parametrised MAX, with clear, enable and terminal-count output.
  - Instantiated twice, for travel and dwell.
- ahead() and the serve mask are combinational logic in the top module.

Test Plan (NUM_FLOORS=4, TRAVEL_TICKS=4, DOOR_TICKS=3):
- Reset mid-travel: rst_n low while MOVING at floor 1 -> immediately floor_o=0, dir_o=00, door_open_o=0, pending_o=0; nothing moves until a new call_req.
- Single up call: call_req=4'b1000 pulse at t0 -> MOVING, dir_o=01 from t0+1. arrive_o pulses with floor_o=1,2,3 at t0+4, t0+8, t0+12. door_open_o=1 for cycles t0+13..t0+15, then IDLE with busy_o=0.
- Current-floor call: at floor 0 IDLE, call_req=4'b0001 -> door_open_o=1 for exactly 3 cycles starting 1 cycle later; dir_o stays 00. Holding door_hold=1 for 5 cycles extends the door-open time to 8 cycles.
- Sweep order: car at 0, pulse calls for floors 3 and then 1 during the first travel -> stops at 1 then 3, each with a 3-cycle door.
- Reverse-sweep call: same travel, then a call for floor 0 while moving up from 1 -> it is served only after the stop at 3, with dir_o=10 on the way down.
- Arrival-cycle call: call for floor 2 asserted exactly on the arrive_o cycle at floor 2 while sweeping to 3 -> the car stops at 2 and pending_o bit 2 clears.
- Hold with repeat call: call for the current floor during DOOR_OPEN -> dwell restarts and the pending bit never sets.

Source files
------------

// File: rtl/elev_pkg.sv
// elev_pkg: shared direction encoding, FSM state type and sizing helper for the elevator car controller.
package elev_pkg;
  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/elev_tick_counter.sv
// elev_tick_counter: counts 0..MAX-1 while enabled and flags the terminal count.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to 0 (wins over en_i, suppresses tc_o)
//   en_i       : advance the count this cycle
//   tc_o       : high on the enabled cycle whose count is MAX-1; the count wraps to 0
module elev_tick_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt_q;

  assign tc_o = en_i & ~clr_i & (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= tc_o ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl: single-car SCAN elevator controller with programmable travel and door-dwell times.
//   clk, rst_n  : clock, asynchronous active-low reset
//   call_req    : per-floor call pulses, latched into pending_o until served
//   door_hold   : holds the dwell count at 0 while the door is open
//   floor_o     : last reached floor
//   dir_o       : 00 none, 01 up, 10 down (non-zero only while moving)
//   door_open_o : door open
//   arrive_o    : one-cycle pulse when floor_o changes
//   pending_o   : latched, not-yet-served requests
//   busy_o      : car not idle or requests outstanding
module elevator_car_ctrl
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS   = 4,
  parameter int TRAVEL_TICKS = 50000000,
  parameter int DOOR_TICKS   = 100000000,
  parameter int FLOOR_W      = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    floor_o,
  output logic [1:0]            dir_o,
  output logic                  door_open_o,
  output logic                  arrive_o,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic                  busy_o
);
  localparam int CNT_W = $clog2(max_int(TRAVEL_TICKS, DOOR_TICKS) + 1);
  localparam logic [NUM_FLOORS-1:0] ONE = 1;

  state_e                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [1:0]            dir_q, dir_d;
  logic                  sweep_q, sweep_d;
  logic                  door_q, arrive_q;
  logic [NUM_FLOORS-1:0] req_all, cur_bit, above, below, serve_mask;
  logic                  here, up_any, dn_any, ahead_sw, ahead_rev;
  logic                  travel_en, step, dwell_en, dwell_clr, dwell_tc, absorb;

  // sweep_q: 1 = up, 0 = down
  assign req_all   = pending_q | call_req;
  assign cur_bit   = ONE << floor_q;
  // at the top floor the shift drops out of range, leaving an empty mask
  assign above     = ~((cur_bit << 1) - ONE);
  assign below     = cur_bit - ONE;
  assign here      = |(req_all & cur_bit);
  assign up_any    = |(req_all & above);
  assign dn_any    = |(req_all & below);
  assign ahead_sw  = sweep_q ? up_any : dn_any;
  assign ahead_rev = sweep_q ? dn_any : up_any;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      IDLE: begin
        if (here) state_d = DOOR_OPEN;
        else if (ahead_sw) state_d = MOVING;
        else if (ahead_rev) begin
          state_d = MOVING;
          sweep_d = ~sweep_q;
        end
      end
      // decisions are taken only on the arrival cycle, when floor_q holds the new floor
      MOVING: state_d = !arrive_q ? MOVING : here ? DOOR_OPEN : ahead_sw ? MOVING : IDLE;
      DOOR_OPEN: state_d = dwell_tc ? IDLE : DOOR_OPEN;
      default: state_d = IDLE;
    endcase
  end

  // the travel counter already runs on the cycle that decides to move,
  // so each step spans exactly TRAVEL_TICKS cycles from the decision
  assign travel_en  = (state_d == MOVING);
  assign absorb     = (state_q == DOOR_OPEN) & |(call_req & cur_bit);
  assign dwell_en   = (state_q == DOOR_OPEN);
  assign dwell_clr  = ~dwell_en | door_hold | absorb;
  assign serve_mask = (((state_d == DOOR_OPEN) & (state_q != DOOR_OPEN)) | absorb) ? cur_bit : '0;
  assign pending_d  = req_all & ~serve_mask;
  assign floor_d    = step ? (sweep_d ? floor_q + 1'b1 : floor_q - 1'b1) : floor_q;
  assign dir_d      = travel_en ? (sweep_d ? DIR_UP : DIR_DOWN) : DIR_NONE;

  elev_tick_counter #(.MAX(TRAVEL_TICKS), .W(CNT_W)) u_travel (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (~travel_en),
    .en_i  (travel_en),
    .tc_o  (step)
  );

  elev_tick_counter #(.MAX(DOOR_TICKS), .W(CNT_W)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (dwell_clr),
    .en_i  (dwell_en),
    .tc_o  (dwell_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      pending_q <= '0;
      sweep_q   <= 1'b1;
      dir_q     <= DIR_NONE;
      door_q    <= 1'b0;
      arrive_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      sweep_q   <= sweep_d;
      dir_q     <= dir_d;
      door_q    <= (state_d == DOOR_OPEN);
      arrive_q  <= step;
    end
  end

  assign floor_o     = floor_q;
  assign dir_o       = dir_q;
  assign door_open_o = door_q;
  assign arrive_o    = arrive_q;
  assign pending_o   = pending_q;
  assign busy_o      = (state_q != IDLE) | (|pending_q);
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb_elevator_car_ctrl: directed checks of the elevator controller with 4 floors, 4-cycle travel, 3-cycle door.
module tb_elevator_car_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] call_req = '0;
  logic       door_hold = 1'b0;
  logic [1:0] floor_o;
  logic [1:0] dir_o;
  logic       door_open_o;
  logic       arrive_o;
  logic [3:0] pending_o;
  logic       busy_o;
  int         n_chk = 0;
  int         n_pass = 0;

  elevator_car_ctrl #(.NUM_FLOORS(4), .TRAVEL_TICKS(4), .DOOR_TICKS(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .call_req    (call_req),
    .door_hold   (door_hold),
    .floor_o     (floor_o),
    .dir_o       (dir_o),
    .door_open_o (door_open_o),
    .arrive_o    (arrive_o),
    .pending_o   (pending_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_floor", floor_o, 0);
    chk("rst_dir", dir_o, 0);
    chk("rst_door", door_open_o, 0);
    chk("rst_arrive", arrive_o, 0);
    chk("rst_pending", pending_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_n = 1'b1;
    step();
    // single up call from floor 0 to floor 3
    call_req = 4'b1000;
    step();
    call_req = '0;
    chk("up_pending", pending_o, 4'b1000);
    chk("up_busy", busy_o, 1);
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("up_floor_c%0d", c), floor_o, c < 4 ? 0 : c < 8 ? 1 : c < 12 ? 2 : 3);
      chk($sformatf("up_arrive_c%0d", c), arrive_o, (c == 4 || c == 8 || c == 12) ? 1 : 0);
      chk($sformatf("up_door_c%0d", c), door_open_o, (c >= 13 && c <= 15) ? 1 : 0);
      chk($sformatf("up_dir_c%0d", c), dir_o, c <= 12 ? 1 : 0);
      step();
    end
    chk("up_end_busy", busy_o, 0);
    chk("up_end_pending", pending_o, 0);
    // head down to floor 0 and reset while moving at floor 1
    call_req = 4'b0001;
    step();
    call_req = '0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("rm_dir_c%0d", c), dir_o, 2);
      step();
    end
    chk("rm_floor_pre", floor_o, 1);
    chk("rm_dir_pre", dir_o, 2);
    rst_n = 1'b0;
    #1;
    chk("rm_floor", floor_o, 0);
    chk("rm_dir", dir_o, 0);
    chk("rm_door", door_open_o, 0);
    chk("rm_pending", pending_o, 0);
    step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("rm_idle_floor", floor_o, 0);
    chk("rm_idle_dir", dir_o, 0);
    chk("rm_idle_busy", busy_o, 0);
    // current-floor call
    call_req = 4'b0001;
    step();
    call_req = '0;
    chk("cur_pending", pending_o, 0);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("cur_door_c%0d", c), door_open_o, c <= 3 ? 1 : 0);
      chk($sformatf("cur_dir_c%0d", c), dir_o, 0);
      step();
    end
    // door_hold for 5 cycles stretches the door to 8 cycles
    call_req = 4'b0001;
    step();
    call_req = '0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 1) door_hold = 1'b1;
      if (c == 6) door_hold = 1'b0;
      chk($sformatf("hold_door_c%0d", c), door_open_o, c <= 8 ? 1 : 0);
      step();
    end
    chk("hold_busy", busy_o, 0);
    // sweep order 1 then 3, plus a reverse-sweep call for 0 served last
    call_req = 4'b1000;
    step();
    for (int c = 1; c <= 36; c++) begin
      call_req = c == 1 ? 4'b0010 : c == 10 ? 4'b0001 : 4'b0000;
      chk($sformatf("sw_floor_c%0d", c), floor_o,
          c < 4 ? 0 : c < 12 ? 1 : c < 16 ? 2 : c < 24 ? 3 : c < 28 ? 2 : c < 32 ? 1 : 0);
      chk($sformatf("sw_door_c%0d", c), door_open_o,
          ((c >= 5 && c <= 7) || (c >= 17 && c <= 19) || (c >= 33 && c <= 35)) ? 1 : 0);
      chk($sformatf("sw_dir_c%0d", c), dir_o,
          (c <= 4 || (c >= 9 && c <= 16)) ? 1 : (c >= 21 && c <= 32) ? 2 : 0);
      chk($sformatf("sw_arrive_c%0d", c), arrive_o,
          (c == 4 || c == 12 || c == 16 || c == 24 || c == 28 || c == 32) ? 1 : 0);
      if (c == 12) chk("sw_pending_c12", pending_o, 4'b1001);
      step();
    end
    call_req = '0;
    chk("sw_end_busy", busy_o, 0);
    // call for floor 2 on its arrival cycle while sweeping to 3
    call_req = 4'b1000;
    step();
    for (int c = 1; c <= 20; c++) begin
      call_req = c == 8 ? 4'b0100 : 4'b0000;
      chk($sformatf("arr_floor_c%0d", c), floor_o, c < 4 ? 0 : c < 8 ? 1 : c < 16 ? 2 : 3);
      chk($sformatf("arr_door_c%0d", c), door_open_o,
          ((c >= 9 && c <= 11) || (c >= 17 && c <= 19)) ? 1 : 0);
      if (c == 9) chk("arr_pending_c9", pending_o, 4'b1000);
      step();
    end
    call_req = '0;
    chk("arr_end_busy", busy_o, 0);
    // repeat call for the open floor restarts the dwell
    call_req = 4'b1000;
    step();
    for (int c = 1; c <= 6; c++) begin
      call_req = c == 2 ? 4'b1000 : 4'b0000;
      chk($sformatf("rep_door_c%0d", c), door_open_o, c <= 5 ? 1 : 0);
      chk($sformatf("rep_pending_c%0d", c), pending_o, 0);
      step();
    end
    call_req = '0;
    chk("rep_busy", busy_o, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
